// File: rtl/pool3_flatten_reader.sv
// pool3_flatten_reader: streams the pooled layer-3 feature map out of BRAM as a flat vector
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle pulse, begins a full readout (ignored unless idle)
//   busy, done          busy during issue/drain, done pulses once after the last beat
//   bram_en, bram_addr  BRAM read port, bram_dout returns RD_LAT cycles after bram_en
//   m_data, m_valid, m_ready, m_last  valid/ready output stream, m_last on the final element
module pool3_flatten_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 128,
  parameter int OUT_HEIGHT = 3,
  parameter int OUT_WIDTH  = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int HWC_ORDER  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);
  localparam int TOTAL = CHANNELS * OUT_HEIGHT * OUT_WIDTH;
  localparam int HW    = OUT_HEIGHT * OUT_WIDTH;
  localparam int IW    = $clog2(TOTAL + 1);
  localparam int CW    = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int HB    = OUT_HEIGHT > 1 ? $clog2(OUT_HEIGHT) : 1;
  localparam int WB    = OUT_WIDTH > 1 ? $clog2(OUT_WIDTH) : 1;
  localparam int PW    = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [HB-1:0]   h_q, h_d;
  logic [WB-1:0]   w_q, w_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RD_LAT-1:0] vld_q, lst_q;
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wp_q, rp_q;
  logic [NW-1:0]   cnt_q;
  logic            c_end, h_end, w_end, last_issue, wr, rd;

  always_comb begin
    c_end      = c_q == CW'(CHANNELS - 1);
    h_end      = h_q == HB'(OUT_HEIGHT - 1);
    w_end      = w_q == WB'(OUT_WIDTH - 1);
    // credit covers both queued entries and reads still in the BRAM pipeline
    bram_en    = state_q == ISSUE && (32'(cnt_q) + $countones(vld_q) < FIFO_DEPTH);
    bram_addr  = ADDR_WIDTH'(32'(c_q) * HW + 32'(h_q) * OUT_WIDTH + 32'(w_q));
    last_issue = bram_en && idx_q == IW'(TOTAL - 1);
    wr         = vld_q[RD_LAT-1];
    m_valid    = cnt_q != '0;
    rd         = m_valid && m_ready;
    m_data     = m_valid ? mem_q[rp_q][DATA_WIDTH-1:0] : '0;
    m_last     = m_valid && mem_q[rp_q][DATA_WIDTH];
    busy       = state_q == ISSUE || state_q == DRAIN;
    done       = state_q == DONE;
    state_d    = state_q == IDLE  ? (start ? ISSUE : IDLE) :
                 state_q == ISSUE ? (last_issue ? DRAIN : ISSUE) :
                 state_q == DRAIN ? (rd && m_last ? DONE : DRAIN) : IDLE;
    c_d   = c_q;
    h_d   = h_q;
    w_d   = w_q;
    idx_d = idx_q;
    if (state_q == IDLE && start) begin
      {c_d, h_d, w_d, idx_d} = '0;
    end else if (bram_en) begin
      idx_d = idx_q == IW'(TOTAL) ? idx_q : idx_q + 1'b1;
      if (HWC_ORDER != 0) begin
        c_d = c_end ? '0 : c_q + 1'b1;
        w_d = c_end ? (w_end ? '0 : w_q + 1'b1) : w_q;
        h_d = c_end && w_end ? (h_end ? '0 : h_q + 1'b1) : h_q;
      end else begin
        w_d = w_end ? '0 : w_q + 1'b1;
        h_d = w_end ? (h_end ? '0 : h_q + 1'b1) : h_q;
        c_d = w_end && h_end ? (c_end ? '0 : c_q + 1'b1) : c_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      h_q     <= '0;
      w_q     <= '0;
      idx_q   <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      h_q      <= h_d;
      w_q      <= w_d;
      idx_q    <= idx_d;
      vld_q[0] <= bram_en;
      lst_q[0] <= last_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
      if (wr) wp_q <= wp_q == PW'(FIFO_DEPTH - 1) ? '0 : wp_q + 1'b1;
      if (rd) rp_q <= rp_q == PW'(FIFO_DEPTH - 1) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + NW'(wr) - NW'(rd);
    end
  end

  // storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= {lst_q[RD_LAT-1], bram_dout};
  end
endmodule

// File: tb/tb_pool3_flatten_reader.sv
// tb_pool3_flatten_reader: checks both stream orders against a reference readout model
module tb_pool3_flatten_reader;
  localparam int C = 128, H = 3, W = 4, N = C * H * W, BUDGET = 20000;

  logic clk = 0, rst_n = 0, start = 0, m_ready = 0;
  always #5 clk = ~clk;

  logic       en[2], valid[2], last[2], busy[2], done[2];
  logic [10:0] addr[2];
  logic [7:0] data[2], p1[2], p2[2];
  logic [7:0] mem [N];

  int total = 0, bad = 0;
  int issued[2], acc[2], ph[2], ndone[2];
  bit hold_v[2], hold_l[2];
  logic [7:0] hold_d[2];

  pool3_flatten_reader #(.HWC_ORDER(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
    .bram_en(en[0]), .bram_addr(addr[0]), .bram_dout(p2[0]),
    .m_data(data[0]), .m_valid(valid[0]), .m_ready(m_ready), .m_last(last[0]));

  pool3_flatten_reader #(.HWC_ORDER(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
    .bram_en(en[1]), .bram_addr(addr[1]), .bram_dout(p2[1]),
    .m_data(data[1]), .m_valid(valid[1]), .m_ready(m_ready), .m_last(last[1]));

  // two-cycle BRAM read pipeline per instance
  always @(posedge clk) begin
    p1[0] <= mem[addr[0]];
    p2[0] <= p1[0];
    p1[1] <= mem[addr[1]];
    p2[1] <= p1[1];
  end

  // beat k of a readout comes from this BRAM address
  function automatic int exp_addr(input int order, input int k);
    if (order == 0) return k;
    return (k % C) * H * W + k / C;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic cyc(input bit rdy, input bit st);
    m_ready = rdy;
    start = st;
    for (int i = 0; i < 2; i++) begin
      chk("busy", i, busy[i], ph[i] == 1);
      chk("done", i, done[i], ph[i] == 2);
      if (done[i] === 1'b1) ndone[i]++;
      if (hold_v[i]) begin
        chk("hold_valid", i, valid[i], 1);
        chk("hold_data", i, data[i], hold_d[i]);
        chk("hold_last", i, last[i], hold_l[i]);
      end
      if (en[i] === 1'b1) begin
        chk("overissue", i, issued[i] < N, 1);
        chk("addr", i, addr[i], exp_addr(i, issued[i]));
        issued[i]++;
        chk("credit", i, issued[i] - acc[i] <= 4, 1);
      end
      hold_v[i] = valid[i] === 1'b1 && !rdy;
      hold_d[i] = data[i];
      hold_l[i] = last[i];
      if (valid[i] === 1'b1 && rdy) begin
        chk("overbeat", i, acc[i] < N, 1);
        if (acc[i] < N) chk("data", i, data[i], mem[exp_addr(i, acc[i])]);
        chk("last", i, last[i], acc[i] == N - 1);
        acc[i]++;
        if (ph[i] == 1 && acc[i] == N) ph[i] = 2;
      end else if (ph[i] == 2) begin
        ph[i] = 0;
      end else if (ph[i] == 0 && st) begin
        ph[i] = 1;
        issued[i] = 0;
        acc[i] = 0;
        ndone[i] = 0;
      end
      if (ph[i] == 2 && !(valid[i] === 1'b1 && rdy)) ph[i] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    start = 0;
    m_ready = 0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, busy[i], 0);
      chk("rst_done", i, done[i], 0);
      chk("rst_en", i, en[i], 0);
      chk("rst_addr", i, addr[i], 0);
      chk("rst_valid", i, valid[i], 0);
      chk("rst_last", i, last[i], 0);
      chk("rst_data", i, data[i], 0);
      ph[i] = 0;
      issued[i] = 0;
      acc[i] = 0;
      ndone[i] = 0;
      hold_v[i] = 0;
    end
  endtask

  task automatic run(input int pct, input int stall, input int abort_at, input bit spam);
    int n = 0;
    bit rdy;
    cyc(1, 1);
    while (!(ph[0] == 2 && ph[1] == 2) && n < BUDGET) begin
      if (abort_at >= 0 && acc[0] >= abort_at) begin
        do_reset(1);
        repeat (20) cyc(1, 0);
        for (int i = 0; i < 2; i++) chk("abort_no_done", i, ndone[i], 0);
        return;
      end
      if (stall > 0 && n == stall)
        for (int i = 0; i < 2; i++) begin
          chk("stall_reads", i, issued[i], 4);
          chk("stall_beats", i, acc[i], 0);
        end
      rdy = n < stall ? 1'b0 : $urandom_range(99) < pct;
      cyc(rdy, spam && $urandom_range(7) == 0);
      n++;
    end
    chk("timeout", 0, n < BUDGET, 1);
    cyc(1, spam);
    repeat (6) cyc(1, 0);
    for (int i = 0; i < 2; i++) begin
      chk("one_done", i, ndone[i], 1);
      chk("issued_total", i, issued[i], N);
      chk("beats_total", i, acc[i], N);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; issued[i] = 0; acc[i] = 0; ndone[i] = 0; hold_v[i] = 0;
    end
    do_reset(3);
    repeat (3) cyc(1, 0);
    run(100, 0, -1, 0);
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    run(50, 0, -1, 0);
    run(100, 100, -1, 0);
    run(100, 0, 700, 0);
    run(100, 0, -1, 0);
    run(60, 0, -1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
